// File: rtl/vx_dotn_pkg.sv
// Shared types and helpers for the packed multi-precision dot-product unit.
package vx_dotn_pkg;

  typedef enum logic [1:0] {
    MODE_I8   = 2'd0,
    MODE_I4   = 2'd1,
    MODE_I16  = 2'd2,
    MODE_RSVD = 2'd3
  } dotn_mode_e;

  localparam int EW_I4  = 4;
  localparam int EW_I8  = 8;
  localparam int EW_I16 = 16;

  function automatic int elems_per_reg(input int xlen, input dotn_mode_e mode);
    int n;
    case (mode)
      MODE_I8:  n = xlen / EW_I8;
      MODE_I4:  n = xlen / EW_I4;
      MODE_I16: n = xlen / EW_I16;
      default:  n = 0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vx_dotn_lane.sv
// One lane of the dot-product datapath: unpack/extend/multiply on one side of
// the product register, reduce plus accumulate on the other.
module vx_dotn_lane
  import vx_dotn_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int NSLOT = elems_per_reg(XLEN, MODE_I4)
) (
  input  dotn_mode_e                   mode_i,
  input  logic                         is_signed_i,
  input  logic                         accum_i,
  input  logic [XLEN-1:0]              rs1_i,
  input  logic [XLEN-1:0]              rs2_i,
  input  logic [XLEN-1:0]              rs3_i,
  output logic [NSLOT-1:0][XLEN-1:0]   prod_o,
  output logic [XLEN-1:0]              addend_o,
  input  logic [NSLOT-1:0][XLEN-1:0]   prod_i,
  input  logic [XLEN-1:0]              addend_i,
  output logic [XLEN-1:0]              result_o
);

  // Products are only needed modulo 2^XLEN, so each element is extended to XLEN.
  function automatic logic [XLEN-1:0] extend(input logic [15:0] raw, input int unsigned ew,
                                             input logic sgn);
    logic [XLEN-1:0] t;
    int unsigned     sh;
    sh = XLEN - ew;
    t  = {{(XLEN-16){1'b0}}, raw} << sh;
    if (sgn) begin
      t = $unsigned($signed(t) >>> sh);
    end else begin
      t = t >> sh;
    end
    return t;
  endfunction

  logic [NSLOT-1:0][XLEN-1:0] a_ext_s;
  logic [NSLOT-1:0][XLEN-1:0] b_ext_s;

  // Slots beyond the element count of the mode (and all slots in reserved mode) stay zero.
  always_comb begin
    a_ext_s = '0;
    b_ext_s = '0;
    case (mode_i)
      MODE_I4: begin
        for (int k = 0; k < XLEN / EW_I4; k++) begin
          a_ext_s[k] = extend(16'(rs1_i[k*EW_I4 +: EW_I4]), EW_I4, is_signed_i);
          b_ext_s[k] = extend(16'(rs2_i[k*EW_I4 +: EW_I4]), EW_I4, is_signed_i);
        end
      end
      MODE_I8: begin
        for (int k = 0; k < XLEN / EW_I8; k++) begin
          a_ext_s[k] = extend(16'(rs1_i[k*EW_I8 +: EW_I8]), EW_I8, is_signed_i);
          b_ext_s[k] = extend(16'(rs2_i[k*EW_I8 +: EW_I8]), EW_I8, is_signed_i);
        end
      end
      MODE_I16: begin
        for (int k = 0; k < XLEN / EW_I16; k++) begin
          a_ext_s[k] = extend(rs1_i[k*EW_I16 +: EW_I16], EW_I16, is_signed_i);
          b_ext_s[k] = extend(rs2_i[k*EW_I16 +: EW_I16], EW_I16, is_signed_i);
        end
      end
      default: begin
        a_ext_s = '0;
        b_ext_s = '0;
      end
    endcase
  end

  always_comb begin
    for (int k = 0; k < NSLOT; k++) begin
      prod_o[k] = a_ext_s[k] * b_ext_s[k];
    end
  end

  // Reserved mode must produce zero even when accumulation is requested.
  always_comb begin
    if (accum_i && (mode_i != MODE_RSVD)) begin
      addend_o = rs3_i;
    end else begin
      addend_o = '0;
    end
  end

  always_comb begin
    result_o = addend_i;
    for (int k = 0; k < NSLOT; k++) begin
      result_o = result_o + prod_i[k];
    end
  end

endmodule

// File: rtl/vx_alu_dotn.sv
// Elastic LATENCY-stage packed dot-product unit: NUM_LANES lane datapaths, a
// valid/tag shift chain sharing one global advance enable, and a retire counter.
module vx_alu_dotn
  import vx_dotn_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int XLEN      = 32,
  parameter int LATENCY   = 2,
  parameter int TAG_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [1:0]                mode_in,
  input  logic                      is_signed_in,
  input  logic                      accum_in,
  input  logic [NUM_LANES*XLEN-1:0] rs1_data,
  input  logic [NUM_LANES*XLEN-1:0] rs2_data,
  input  logic [NUM_LANES*XLEN-1:0] rs3_data,
  input  logic [TAG_WIDTH-1:0]      tag_in,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [NUM_LANES*XLEN-1:0] data_out,
  output logic [TAG_WIDTH-1:0]      tag_out,
  output logic [31:0]               op_count
);

  localparam int NSLOT = elems_per_reg(XLEN, MODE_I4);

  logic                 en_s;
  dotn_mode_e           mode_s;
  logic [LATENCY-1:0]   valid_q;
  logic [TAG_WIDTH-1:0] tag_q [LATENCY];
  logic [31:0]          op_count_q;
  logic [31:0]          op_count_d;

  assign en_s      = ~valid_q[LATENCY-1] | ready_out;
  assign ready_in  = en_s;
  assign valid_out = valid_q[LATENCY-1];
  assign tag_out   = tag_q[LATENCY-1];
  assign op_count  = op_count_q;
  assign mode_s    = dotn_mode_e'(mode_in);

  // Valid and tag advance together; the whole pipe freezes when the output is blocked.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else if (en_s) begin
      valid_q[0] <= valid_in;
      tag_q[0]   <= tag_in;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    if (valid_q[LATENCY-1] && ready_out) begin
      op_count_d = op_count_q + 32'd1;
    end else begin
      op_count_d = op_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_count_q <= 32'd0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [NSLOT-1:0][XLEN-1:0] prod_s;
    logic [NSLOT-1:0][XLEN-1:0] prod_in_s;
    logic [XLEN-1:0]            addend_s;
    logic [XLEN-1:0]            addend_in_s;
    logic [XLEN-1:0]            result_s;
    logic [XLEN-1:0]            lane_out_s;

    vx_dotn_lane #(.XLEN(XLEN)) u_lane (
      .mode_i      (mode_s),
      .is_signed_i (is_signed_in),
      .accum_i     (accum_in),
      .rs1_i       (rs1_data[l*XLEN +: XLEN]),
      .rs2_i       (rs2_data[l*XLEN +: XLEN]),
      .rs3_i       (rs3_data[l*XLEN +: XLEN]),
      .prod_o      (prod_s),
      .addend_o    (addend_s),
      .prod_i      (prod_in_s),
      .addend_i    (addend_in_s),
      .result_o    (result_s)
    );

    if (LATENCY == 1) begin : g_single
      logic [XLEN-1:0] res_q;

      assign prod_in_s   = prod_s;
      assign addend_in_s = addend_s;

      always_ff @(posedge clk) begin
        if (reset) begin
          res_q <= '0;
        end else if (en_s) begin
          res_q <= result_s;
        end
      end

      assign lane_out_s = res_q;
    end else begin : g_multi
      logic [NSLOT-1:0][XLEN-1:0] prod_q;
      logic [XLEN-1:0]            addend_q;
      logic [XLEN-1:0]            res_q [1:LATENCY-1];

      assign prod_in_s   = prod_q;
      assign addend_in_s = addend_q;

      // Stage 0 holds raw products; stage 1 reduces; later stages only delay.
      always_ff @(posedge clk) begin
        if (reset) begin
          prod_q   <= '0;
          addend_q <= '0;
          for (int j = 1; j < LATENCY; j++) begin
            res_q[j] <= '0;
          end
        end else if (en_s) begin
          prod_q   <= prod_s;
          addend_q <= addend_s;
          res_q[1] <= result_s;
          for (int j = 2; j < LATENCY; j++) begin
            res_q[j] <= res_q[j-1];
          end
        end
      end

      assign lane_out_s = res_q[LATENCY-1];
    end

    assign data_out[l*XLEN +: XLEN] = lane_out_s;
  end

endmodule

// File: tb/tb_vx_alu_dotn.sv
// Self-checking bench for vx_alu_dotn: directed vector table, randomized traffic
// against an element-level arithmetic model, and backpressure/reset sequences.
module tb_vx_alu_dotn;
  import vx_dotn_pkg::*;

  localparam int NL  = 4;
  localparam int XL  = 32;
  localparam int LAT = 2;
  localparam int TW  = 8;
  localparam int DW  = NL * XL;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic          ready_in;
  logic [1:0]    mode_in;
  logic          is_signed_in;
  logic          accum_in;
  logic [DW-1:0] rs1_data, rs2_data, rs3_data;
  logic [TW-1:0] tag_in;
  logic          valid_out;
  logic          ready_out;
  logic [DW-1:0] data_out;
  logic [TW-1:0] tag_out;
  logic [31:0]   op_count;

  always #5 clk = ~clk;

  vx_alu_dotn #(.NUM_LANES(NL), .XLEN(XL), .LATENCY(LAT), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .mode_in(mode_in), .is_signed_in(is_signed_in), .accum_in(accum_in),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs3_data(rs3_data), .tag_in(tag_in),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
    .tag_out(tag_out), .op_count(op_count)
  );

  typedef struct {
    string         name;
    logic [1:0]    mode;
    logic          sgn;
    logic          acc;
    logic [XL-1:0] a, b, c, exp;
  } vec_t;

  vec_t          vecs [9];
  int            n_chk = 0;
  int            n_fail = 0;
  int            retired_cnt = 0;
  logic [DW-1:0] exp_data_q [$];
  logic [TW-1:0] exp_tag_q [$];
  logic [DW-1:0] ret_data_q [$];
  logic [TW-1:0] ret_tag_q [$];
  logic          acc_flag, ret_flag, rdy_smp;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: sum of extended element products, then optional rs3, modulo 2^XL.
  function automatic logic [XL-1:0] ref_lane(input logic [XL-1:0] a, b, c, input logic [1:0] mode,
                                             input logic sgn, input logic acc);
    int ew;
    longint sum, ea, eb;
    logic [63:0] ua, ub, mask;
    case (mode)
      2'd0: ew = 8;
      2'd1: ew = 4;
      2'd2: ew = 16;
      default: return '0;
    endcase
    mask = (64'd1 << ew) - 64'd1;
    sum = 0;
    for (int k = 0; k < XL / ew; k++) begin
      ua = 64'(a >> (k * ew)) & mask;
      ub = 64'(b >> (k * ew)) & mask;
      ea = longint'(ua);
      eb = longint'(ub);
      if (sgn && ea >= (longint'(1) << (ew - 1))) ea -= longint'(1) << ew;
      if (sgn && eb >= (longint'(1) << (ew - 1))) eb -= longint'(1) << ew;
      sum += ea * eb;
    end
    if (acc) sum += longint'(64'(c));
    return sum[XL-1:0];
  endfunction

  function automatic logic [DW-1:0] ref_txn(input logic [DW-1:0] a, b, c, input logic [1:0] mode,
                                            input logic sgn, input logic acc);
    logic [DW-1:0] r;
    for (int l = 0; l < NL; l++) begin
      r[l*XL +: XL] = ref_lane(a[l*XL +: XL], b[l*XL +: XL], c[l*XL +: XL], mode, sgn, acc);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] bcast(input logic [XL-1:0] w);
    logic [DW-1:0] r;
    for (int l = 0; l < NL; l++) r[l*XL +: XL] = w;
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    if ($urandom_range(0, 5) == 0) r = {DW{1'b1}};
    return r;
  endfunction

  task automatic drive(input logic v, input logic [1:0] m, input logic s, input logic a,
                       input logic [DW-1:0] r1, r2, r3, input logic [TW-1:0] t);
    valid_in = v; mode_in = m; is_signed_in = s; accum_in = a;
    rs1_data = r1; rs2_data = r2; rs3_data = r3; tag_in = t;
  endtask

  // One clock: sample handshakes mid-cycle, update the scoreboard, advance to next negedge.
  task automatic step();
    #1;
    acc_flag = valid_in && ready_in && !reset;
    ret_flag = valid_out && ready_out && !reset;
    rdy_smp  = ready_in;
    if (reset) begin
      exp_data_q.delete();
      exp_tag_q.delete();
      retired_cnt = 0;
    end else begin
      if (ret_flag) begin
        chk("sb_pending", DW'(exp_data_q.size() > 0), DW'(1));
        if (exp_data_q.size() > 0) begin
          chk("sb_data", data_out, exp_data_q.pop_front());
          chk("sb_tag", DW'(tag_out), DW'(exp_tag_q.pop_front()));
        end
        ret_data_q.push_back(data_out);
        ret_tag_q.push_back(tag_out);
        retired_cnt++;
      end
      if (acc_flag) begin
        exp_data_q.push_back(ref_txn(rs1_data, rs2_data, rs3_data, mode_in, is_signed_in, accum_in));
        exp_tag_q.push_back(tag_in);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, idx, stall_cnt;
    logic started, stalling;
    logic [DW-1:0] snap_d;
    logic [TW-1:0] snap_t;

    vecs[0] = '{"i8s",     2'd0, 1'b1, 1'b0, 32'h01FF0302, 32'h04050607, 32'hDEADBEEF, 32'h0000001F};
    vecs[1] = '{"i8u",     2'd0, 1'b0, 1'b0, 32'h01FF0302, 32'h04050607, 32'h00000000, 32'h0000051F};
    vecs[2] = '{"i4s",     2'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h11111111, 32'h00000000, 32'hFFFFFFF8};
    vecs[3] = '{"i4u",     2'd1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h11111111, 32'h00000000, 32'h00000078};
    vecs[4] = '{"i16s",    2'd2, 1'b1, 1'b0, 32'h80008000, 32'h80008000, 32'h00000000, 32'h80000000};
    vecs[5] = '{"i16s_acc",2'd2, 1'b1, 1'b1, 32'h80008000, 32'h80008000, 32'h80000000, 32'h00000000};
    vecs[6] = '{"rsvd",    2'd3, 1'b1, 1'b1, 32'h01FF0302, 32'h04050607, 32'h12345678, 32'h00000000};
    vecs[7] = '{"i16u",    2'd2, 1'b0, 1'b0, 32'hFFFF0001, 32'h00020003, 32'h00000000, 32'h00020001};
    vecs[8] = '{"i8s_acc", 2'd0, 1'b1, 1'b1, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h00000001, 32'h0000FC05};

    reset = 1'b1; ready_out = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    step(); step();
    reset = 1'b0;
    chk("rst_valid_out", DW'(valid_out), DW'(0));
    chk("rst_data_out", data_out, '0);
    chk("rst_tag_out", DW'(tag_out), DW'(0));
    chk("rst_op_count", DW'(op_count), DW'(0));
    chk("rst_ready_in", DW'(ready_in), DW'(1));

    // Directed table, one transaction at a time with latency measured.
    ready_out = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vecs[i].mode, vecs[i].sgn, vecs[i].acc,
            bcast(vecs[i].a), bcast(vecs[i].b), bcast(vecs[i].c), TW'(i + 16));
      step();
      valid_in = 1'b0;
      lat = 1;
      while (!valid_out && lat < 20) begin step(); lat++; end
      chk({vecs[i].name, "_latency"}, DW'(lat), DW'(LAT));
      chk({vecs[i].name, "_data"}, data_out, bcast(vecs[i].exp));
      chk({vecs[i].name, "_tag"}, DW'(tag_out), DW'(i + 16));
      step();
    end

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), rand_vec(), rand_vec(), rand_vec(), TW'($urandom()));
      ready_out = ($urandom_range(0, 3) != 0);
      step();
    end
    valid_in = 1'b0; ready_out = 1'b1;
    repeat (LAT + 4) step();
    chk("rand_drained", DW'(exp_data_q.size()), DW'(0));
    chk("rand_op_count", DW'(op_count), DW'(retired_cnt));

    // Back-to-back with a 3-cycle output stall once the pipe is full.
    reset = 1'b1; step(); reset = 1'b0;
    ret_data_q.delete(); ret_tag_q.delete();
    idx = 0; stall_cnt = 0; started = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (idx >= 8 && exp_data_q.size() == 0) break;
      if (!started && valid_out) started = 1'b1;
      stalling = started && (stall_cnt < 3);
      ready_out = !stalling;
      drive(idx < 8, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            rand_vec(), rand_vec(), rand_vec(), TW'(idx));
      snap_d = data_out; snap_t = tag_out;
      step();
      if (acc_flag) idx++;
      if (stalling) begin
        stall_cnt++;
        chk("stall_ready_in", DW'(rdy_smp), DW'(0));
        chk("stall_data_hold", data_out, snap_d);
        chk("stall_tag_hold", DW'(tag_out), DW'(snap_t));
      end
    end
    valid_in = 1'b0; ready_out = 1'b1;
    chk("b2b_stall_cycles", DW'(stall_cnt), DW'(3));
    chk("b2b_retired", DW'(ret_tag_q.size()), DW'(8));
    for (int i = 0; i < ret_tag_q.size() && i < 8; i++) chk("b2b_order", DW'(ret_tag_q[i]), DW'(i));
    chk("b2b_op_count", DW'(op_count), DW'(8));

    // Reserved mode sandwiched between int8 transactions.
    ret_data_q.delete(); ret_tag_q.delete();
    drive(1'b1, 2'd0, 1'b1, 1'b0, bcast(32'h01FF0302), bcast(32'h04050607), bcast(32'h0), 8'hA1);
    step();
    drive(1'b1, 2'd3, 1'b1, 1'b1, bcast(32'h01FF0302), bcast(32'h04050607), bcast(32'h12345678), 8'hA2);
    step();
    drive(1'b1, 2'd0, 1'b0, 1'b0, bcast(32'h01FF0302), bcast(32'h04050607), bcast(32'h0), 8'hA3);
    step();
    valid_in = 1'b0;
    repeat (LAT + 3) step();
    chk("mix_retired", DW'(ret_tag_q.size()), DW'(3));
    if (ret_tag_q.size() == 3) begin
      chk("mix_i8s_data", ret_data_q[0], bcast(32'h0000001F));
      chk("mix_rsvd_data", ret_data_q[1], '0);
      chk("mix_rsvd_tag", DW'(ret_tag_q[1]), DW'(8'hA2));
      chk("mix_i8u_data", ret_data_q[2], bcast(32'h0000051F));
      chk("mix_i8u_tag", DW'(ret_tag_q[2]), DW'(8'hA3));
    end

    // Reset while two transactions are in flight.
    ready_out = 1'b0;
    drive(1'b1, 2'd0, 1'b1, 1'b0, rand_vec(), rand_vec(), rand_vec(), 8'hC1);
    step();
    drive(1'b1, 2'd1, 1'b0, 1'b1, rand_vec(), rand_vec(), rand_vec(), 8'hC2);
    step();
    valid_in = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0; ready_out = 1'b1;
    chk("midrst_op_count", DW'(op_count), DW'(0));
    for (int i = 0; i < 4; i++) begin
      chk("midrst_valid_out", DW'(valid_out), DW'(0));
      step();
    end
    drive(1'b1, 2'd2, 1'b1, 1'b1, rand_vec(), rand_vec(), rand_vec(), 8'hC3);
    step();
    valid_in = 1'b0;
    lat = 1;
    while (!valid_out && lat < 20) begin step(); lat++; end
    chk("midrst_latency", DW'(lat), DW'(LAT));
    chk("midrst_tag", DW'(tag_out), DW'(8'hC3));
    repeat (3) step();
    chk("midrst_final_count", DW'(op_count), DW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
